// File: rtl/gray_ptr_pkg.sv
// Shared Gray/binary helpers and the default pointer type for the async-FIFO pointer blocks.
// The helpers work on 32-bit vectors; narrower pointers are zero-extended by the caller.
package gray_ptr_pkg;

    localparam int unsigned DefAddrWidth = 4;
    localparam int unsigned FnWidth      = 32;

    typedef logic [DefAddrWidth:0] ptr_t;

    function automatic logic [FnWidth-1:0] bin2gray(input logic [FnWidth-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FnWidth-1:0] gray2bin(input logic [FnWidth-1:0] g);
        logic [FnWidth-1:0] b;
        b = '0;
        b[FnWidth-1] = g[FnWidth-1];
        for (int i = FnWidth - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/IncGrayC.sv
// Gray-code incrementer: Z = gray(bin(A) + CI). Speed selects a parallel (per-bit XOR
// reduction) or a ripple Gray-to-binary conversion; both give identical results.
module IncGrayC #(
    parameter int unsigned Width = 5,
    parameter int unsigned Speed = 1
) (
    input  logic [Width-1:0] A,
    input  logic             CI,
    output logic [Width-1:0] Z
);

    logic [Width-1:0] bin;
    logic [Width-1:0] sum;

    if (Speed != 0) begin : g_fast
        for (genvar i = 0; i < Width; i++) begin : g_bit
            assign bin[i] = ^A[Width-1:i];
        end
    end else begin : g_ripple
        always_comb begin
            logic [Width-1:0] r;
            r = '0;
            r[Width-1] = A[Width-1];
            for (int i = Width - 2; i >= 0; i--) begin
                r[i] = r[i+1] ^ A[i];
            end
            bin = r;
        end
    end

    assign sum = bin + {{(Width-1){1'b0}}, CI};
    assign Z   = sum ^ (sum >> 1);

endmodule

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchronizer for the opposite side's Gray pointer; each bit has its own chain.
module gray_ptr_sync #(
    parameter int unsigned Width  = 5,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] chain_q [Stages];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Stages; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/gray_fifo_ptr.sv
// One side of an async-FIFO pointer pair: Gray pointer, binary address, remote sync, full/empty.
// Optional almost-full/almost-empty flag built when GRAY_PTR_ALMOST_EN is defined.
module gray_fifo_ptr
    import gray_ptr_pkg::*;
#(
    parameter int unsigned AddrWidth    = 4,
    parameter bit          IsWrite      = 1'b1,
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned AlmostThresh = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               inc_i,
    input  logic [AddrWidth:0] remote_gray_i,
    output logic [AddrWidth:0] ptr_gray_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic               flag_o,
    output logic               almost_o
);

    localparam int unsigned PtrW = AddrWidth + 1;
    typedef logic [AddrWidth:0] lptr_t;

    // Full means the remote pointer differs from ours only in the top two Gray bits.
    localparam lptr_t FullMask = lptr_t'(3) << (AddrWidth - 1);
    localparam logic  FlagRst  = !IsWrite;

    if (SyncStages < 2) begin : g_sync_chk
        $error("gray_fifo_ptr: SyncStages must be at least 2");
    end
    if (AlmostThresh > (2 ** AddrWidth)) begin : g_thresh_chk
        $error("gray_fifo_ptr: AlmostThresh exceeds FIFO depth");
    end

    lptr_t ptr_q, ptr_d;
    lptr_t bin_q, bin_d;
    logic  flag_q, flag_d;
    logic  almost_q, almost_d;
    lptr_t rs;
    logic  acc;

    assign acc = inc_i & ~flag_q;

    IncGrayC #(
        .Width (PtrW),
        .Speed (1)
    ) u_inc (
        .A  (ptr_q),
        .CI (acc),
        .Z  (ptr_d)
    );

    gray_ptr_sync #(
        .Width  (PtrW),
        .Stages (SyncStages)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (remote_gray_i),
        .q_o    (rs)
    );

    assign bin_d = bin_q + {{AddrWidth{1'b0}}, acc};

    always_comb begin
        flag_d = 1'b0;
        if (IsWrite) begin
            flag_d = (ptr_d == (rs ^ FullMask));
        end else begin
            flag_d = (ptr_d == rs);
        end
    end

`ifdef GRAY_PTR_ALMOST_EN
    localparam logic [FnWidth-1:0] PtrMask = FnWidth'((64'd1 << PtrW) - 64'd1);

    logic [FnWidth-1:0] rb_w;
    logic [FnWidth-1:0] bin_ext;
    logic [FnWidth-1:0] level_w;

    assign rb_w    = gray2bin(FnWidth'(rs));
    assign bin_ext = FnWidth'(bin_d);

    always_comb begin
        level_w  = '0;
        almost_d = 1'b0;
        if (IsWrite) begin
            level_w  = (bin_ext - rb_w) & PtrMask;
            almost_d = (level_w >= FnWidth'((2 ** AddrWidth) - AlmostThresh));
        end else begin
            level_w  = (rb_w - bin_ext) & PtrMask;
            almost_d = (level_w <= FnWidth'(AlmostThresh));
        end
    end
`else
    assign almost_d = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q    <= '0;
            bin_q    <= '0;
            flag_q   <= FlagRst;
            almost_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            bin_q    <= bin_d;
            flag_q   <= flag_d;
            almost_q <= almost_d;
        end
    end

    assign ptr_gray_o = ptr_q;
    assign addr_o     = bin_q[AddrWidth-1:0];
    assign flag_o     = flag_q;
    assign almost_o   = almost_q;

endmodule

// File: tb/tb_gray_fifo_ptr.sv
// Directed bench for gray_fifo_ptr: a write-side and a read-side instance, AddrWidth=2.
module tb_gray_fifo_ptr;

`ifdef GRAY_PTR_ALMOST_EN
    localparam logic AlmostOn = 1'b1;
`else
    localparam logic AlmostOn = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       wr_inc, rd_inc;
    logic [2:0] wr_remote, rd_remote;
    logic [2:0] wr_ptr, rd_ptr;
    logic [1:0] wr_addr, rd_addr;
    logic       wr_full, rd_empty;
    logic       wr_almost, rd_almost;

    int n_pass  = 0;
    int n_total = 0;

    gray_fifo_ptr #(.AddrWidth(2), .IsWrite(1'b1), .SyncStages(2), .AlmostThresh(1)) u_wr (
        .clk_i(clk), .rst_ni(rst_n), .inc_i(wr_inc), .remote_gray_i(wr_remote),
        .ptr_gray_o(wr_ptr), .addr_o(wr_addr), .flag_o(wr_full), .almost_o(wr_almost));

    gray_fifo_ptr #(.AddrWidth(2), .IsWrite(1'b0), .SyncStages(2), .AlmostThresh(1)) u_rd (
        .clk_i(clk), .rst_ni(rst_n), .inc_i(rd_inc), .remote_gray_i(rd_remote),
        .ptr_gray_o(rd_ptr), .addr_o(rd_addr), .flag_o(rd_empty), .almost_o(rd_almost));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] gray3(input int v);
        logic [2:0] b;
        b = v[2:0];
        return b ^ (b >> 1);
    endfunction

    logic [2:0] exp_ptr [5];
    logic [1:0] exp_addr [5];
    logic       exp_full [5];
    logic       exp_alm [5];

    initial begin
        exp_ptr  = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b110};
        exp_addr = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        exp_full = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_alm  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; wr_inc = 1'b0; rd_inc = 1'b0; wr_remote = '0; rd_remote = '0;
        #7;
        chk("rst_wr_ptr", 8'(wr_ptr), 8'h0);
        chk("rst_wr_addr", 8'(wr_addr), 8'h0);
        chk("rst_wr_full", 8'(wr_full), 8'h0);
        chk("rst_wr_almost", 8'(wr_almost), 8'h0);
        chk("rst_rd_ptr", 8'(rd_ptr), 8'h0);
        chk("rst_rd_empty", 8'(rd_empty), 8'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the write side: fourth push raises full, fifth is dropped.
        wr_inc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("fill_ptr%0d", i), 8'(wr_ptr), 8'(exp_ptr[i]));
            chk($sformatf("fill_addr%0d", i), 8'(wr_addr), 8'(exp_addr[i]));
            chk($sformatf("fill_full%0d", i), 8'(wr_full), 8'(exp_full[i]));
            chk($sformatf("fill_alm%0d", i), 8'(wr_almost), 8'(exp_alm[i] & AlmostOn));
        end

        // Remote read pointer advances; full clears after sync + register.
        wr_inc = 1'b0;
        wr_remote = 3'b001;
        tick(); tick();
        chk("unfull_2edges", 8'(wr_full), 8'h1);
        tick();
        chk("unfull_3edges", 8'(wr_full), 8'h0);
        chk("unfull_ptr_hold", 8'(wr_ptr), 8'h6);
        wr_inc = 1'b1;
        tick();
        chk("refill_ptr", 8'(wr_ptr), 8'h7);
        chk("refill_full", 8'(wr_full), 8'h1);
        chk("refill_addr", 8'(wr_addr), 8'h1);
        chk("refill_alm", 8'(wr_almost), 8'(AlmostOn));
        wr_inc = 1'b0;

        // Read side: remote write appears, one pop empties again.
        rd_remote = 3'b001;
        tick(); tick();
        chk("rd_empty_2edges", 8'(rd_empty), 8'h1);
        tick();
        chk("rd_empty_3edges", 8'(rd_empty), 8'h0);
        rd_inc = 1'b1;
        tick();
        chk("pop_ptr", 8'(rd_ptr), 8'h1);
        chk("pop_addr", 8'(rd_addr), 8'h1);
        chk("pop_empty", 8'(rd_empty), 8'h1);
        tick();
        chk("pop_dropped_ptr", 8'(rd_ptr), 8'h1);
        rd_inc = 1'b0;

        // Wrap: remote trails the local pointer so full never rises.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        wr_remote = '0;
        for (int i = 1; i <= 8; i++) begin
            wr_remote = gray3(i - 1);
            wr_inc = 1'b1;
            tick();
            chk($sformatf("wrap_addr%0d", i), 8'(wr_addr), 8'(i % 4));
            chk($sformatf("wrap_full%0d", i), 8'(wr_full), 8'h0);
        end
        chk("wrap_ptr", 8'(wr_ptr), 8'h0);
        wr_inc = 1'b0;

        // Async reset between edges.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        wr_remote = '0;
        wr_inc = 1'b1;
        tick(); tick();
        chk("pre_areset_ptr", 8'(wr_ptr), 8'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_wr_ptr", 8'(wr_ptr), 8'h0);
        chk("areset_wr_addr", 8'(wr_addr), 8'h0);
        chk("areset_wr_full", 8'(wr_full), 8'h0);
        chk("areset_wr_almost", 8'(wr_almost), 8'h0);
        chk("areset_rd_ptr", 8'(rd_ptr), 8'h0);
        chk("areset_rd_empty", 8'(rd_empty), 8'h1);
        wr_inc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
